// File: rtl/vend_pkg.sv
// Shared vending types: coin values, coin select and dispenser state.
// Used by the change dispenser and the vend FSM.
package vend_pkg;

  localparam int COIN_Q_VAL = 25;
  localparam int COIN_D_VAL = 10;
  localparam int COIN_N_VAL = 5;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_Q,
    COIN_D,
    COIN_N
  } coin_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } disp_state_e;

  function automatic logic [2:0] coin_onehot(coin_e c);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (c)
      COIN_Q:  oh = 3'b100;
      COIN_D:  oh = 3'b010;
      COIN_N:  oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change request handshake and completion report between
// the vend FSM (master) and the change dispenser (slave).
interface change_dispenser_if #(
  parameter int AMT_W = 8
) ();

  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] rem_amt;

  modport master (
    output req_valid,
    output req_amount,
    input  req_ready,
    input  done,
    input  short,
    input  rem_amt
  );

  modport slave (
    input  req_valid,
    input  req_amount,
    output req_ready,
    output done,
    output short,
    output rem_amt
  );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero.
// One instance times both the eject pulse and the gap.
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Pays out requested change largest coin first, one
// timed solenoid pulse per coin, then reports the unpaid rest.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   bus,
  input  logic                empty_q,
  input  logic                empty_d,
  input  logic                empty_n,
  output logic                eject_q,
  output logic                eject_d,
  output logic                eject_n,
  output logic                busy
);

  localparam int TMAX =
    (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(COIN_Q_VAL);
  localparam logic [AMT_W-1:0] VAL_D = AMT_W'(COIN_D_VAL);
  localparam logic [AMT_W-1:0] VAL_N = AMT_W'(COIN_N_VAL);

  disp_state_e      state;
  disp_state_e      state_n;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] rem_amt_r;
  logic [2:0]       eject_r;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;
  logic             tmr_last;
  logic             tmr_expire;

  logic             can_q;
  logic             can_d;
  logic             can_n;
  coin_e            coin;
  logic [AMT_W-1:0] coin_val;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  // zero only matters if a timer was loaded with 0
  assign tmr_expire = tmr_last | tmr_zero;

  assign can_q = !empty_q && (remaining >= VAL_Q);
  assign can_d = !can_q && !empty_d &&
                 (remaining >= VAL_D);
  assign can_n = !can_q && !can_d && !empty_n &&
                 (remaining >= VAL_N);

  always_comb begin
    coin     = COIN_NONE;
    coin_val = '0;
    unique case (1'b1)
      can_q: begin
        coin     = COIN_Q;
        coin_val = VAL_Q;
      end
      can_d: begin
        coin     = COIN_D;
        coin_val = VAL_D;
      end
      can_n: begin
        coin     = COIN_N;
        coin_val = VAL_N;
      end
      default: begin
        coin     = COIN_NONE;
        coin_val = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_n = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (coin != COIN_NONE) begin
          state_n  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYC);
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_PULSE: begin
        if (tmr_expire) begin
          state_n  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYC);
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          state_n = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // eject flops rise with the first PULSE cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      rem_amt_r <= '0;
      eject_r   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            remaining <= bus.req_amount;
            rem_amt_r <= '0;
          end
        end
        ST_SELECT: begin
          if (coin != COIN_NONE) begin
            remaining <= remaining - coin_val;
            eject_r   <= coin_onehot(coin);
          end else begin
            rem_amt_r <= remaining;
          end
        end
        ST_PULSE: begin
          if (tmr_expire) begin
            eject_r <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign eject_q = eject_r[2];
  assign eject_d = eject_r[1];
  assign eject_n = eject_r[0];

  assign busy          = (state != ST_IDLE);
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.rem_amt   = rem_amt_r;
  assign bus.short     = (rem_amt_r != '0);

endmodule
